// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions used by the divider and the vedic_16x16
// wrappers.
//   DW          : base operand width (word)
//   word_t      : DW-bit word (divisor, remainder, multiplier operands)
//   dword_t     : 2*DW-bit word (dividend, quotient, product)
//   div_state_t : sequential divider control states
package arith_pkg;

  localparam int unsigned DW = 16;

  typedef logic [DW-1:0]   word_t;
  typedef logic [2*DW-1:0] dword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : arith_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit, shifted in at the LSB
//   divisor_i : denominator
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this iteration
module div_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] rem_o,
  output logic          qbit_o
);

  logic [DW:0]   shifted;
  logic [DW-1:0] diff;

  // The shifted value is DW+1 bits wide, but whenever it is >= divisor the
  // true difference is < divisor, so a DW-bit modular subtract is exact.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted[DW-1:0] - divisor_i;
    qbit_o  = (shifted >= {1'b0, divisor_i});
    rem_o   = qbit_o ? diff : shifted[DW-1:0];
  end

endmodule : div_step

// File: rtl/seq_divider_32by16.sv
// Multi-cycle restoring divider, one quotient bit per clock, MSB first.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : request, accepted only when not busy
//   dividend    : 2*DW-bit numerator, captured on accepted start
//   divisor     : DW-bit denominator, captured on accepted start
//   busy        : iteration in progress
//   valid       : result valid, held until the next accepted start
//   quotient    : 2*DW-bit result quotient
//   remainder   : DW-bit result remainder
//   div_by_zero : divisor was zero for the current result
module seq_divider_32by16 #(
  parameter int unsigned DW = arith_pkg::DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            valid,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);

  import arith_pkg::*;

  localparam int unsigned CW = $clog2(2*DW+1);

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2*DW-1:0] dvd_q;
  logic [DW-1:0]   dsr_q;
  logic [DW-1:0]   rem_q;
  logic [2*DW-1:0] quo_q;
  logic [DW-1:0]   res_rem_q;
  logic            dbz_q;

  logic            accept;
  logic            last_iter;
  logic [DW-1:0]   step_rem;
  logic            step_qbit;

  assign accept    = start && (state_q != RUN);
  assign last_iter = (state_q == RUN) && (cnt_q == CW'(1));

  div_step #(.DW(DW)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[2*DW-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (divisor == '0) ? DONE : RUN;
      RUN:        if (cnt_q == CW'(1)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == RUN);
    valid       = (state_q == DONE);
    quotient    = quo_q;
    remainder   = res_rem_q;
    div_by_zero = dbz_q;
  end

  // Datapath. The dividend register doubles as the quotient accumulator:
  // each iteration shifts out a dividend bit at the top and a quotient bit
  // in at the bottom, so after 2*DW steps it holds the full quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_rem_q <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      dvd_q <= dividend;
      dsr_q <= divisor;
      rem_q <= '0;
      cnt_q <= CW'(2*DW);
      if (divisor == '0) begin
        quo_q     <= '1;
        res_rem_q <= dividend[DW-1:0];
        dbz_q     <= 1'b1;
      end else begin
        dbz_q <= 1'b0;
      end
    end else if (state_q == RUN) begin
      rem_q <= step_rem;
      dvd_q <= {dvd_q[2*DW-2:0], step_qbit};
      cnt_q <= cnt_q - CW'(1);
      if (last_iter) begin
        quo_q     <= {dvd_q[2*DW-2:0], step_qbit};
        res_rem_q <= step_rem;
      end
    end
  end

endmodule : seq_divider_32by16

// File: tb/tb_seq_divider_32by16.sv
module tb_seq_divider_32by16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  seq_divider_32by16 #(.DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0BAD;
  endtask

  // Waits for valid, counting cycles since accept and busy samples.
  // A start with other operands is pulsed at cycle inject_at (-1 = none).
  task automatic wait_done(input string tag, input int exp_cycles, input int inject_at,
                           input logic [31:0] exp_q, input logic [15:0] exp_r,
                           input logic exp_dbz);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    while (!valid && n < 100) begin
      if (busy) bc++;
      start = (n == inject_at);
      if (n == inject_at) begin
        dividend = 32'd999;
        divisor  = 16'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_cycles));
    check({tag, " busy cycles"}, 64'(bc), 64'(exp_cycles));
    check({tag, " valid"}, 64'(valid), 64'd1);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
    check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start_op(32'd144, 16'd12);
    check("144/12 busy after accept", 64'(busy), 64'd1);
    wait_done("144/12", 32, -1, 32'd12, 16'd0, 1'b0);

    // Back-to-back: start issued in the valid cycle
    start_op(32'd195, 16'd13);
    check("b2b1 valid dropped", 64'(valid), 64'd0);
    check("b2b1 busy", 64'(busy), 64'd1);
    wait_done("195/13", 32, -1, 32'd15, 16'd0, 1'b0);
    start_op(32'd4200, 16'd21);
    check("b2b2 valid dropped", 64'(valid), 64'd0);
    wait_done("4200/21", 32, -1, 32'd200, 16'd0, 1'b0);
    start_op(32'd1728, 16'd48);
    check("b2b3 valid dropped", 64'(valid), 64'd0);
    wait_done("1728/48", 32, -1, 32'd36, 16'd0, 1'b0);

    start_op(32'd145, 16'd12);
    wait_done("145/12", 32, -1, 32'd12, 16'd1, 1'b0);
    start_op(32'hFFFF_FFFF, 16'd1);
    wait_done("max/1", 32, -1, 32'hFFFF_FFFF, 16'd0, 1'b0);
    start_op(32'd5, 16'hFFFF);
    wait_done("5/ffff", 32, -1, 32'd0, 16'd5, 1'b0);

    start_op(32'h0001_2345, 16'd0);
    wait_done("div0", 0, -1, 32'hFFFF_FFFF, 16'h2345, 1'b1);

    // Start mid-run must be ignored: 1000/7 = 142 rem 6
    start_op(32'd1000, 16'd7);
    wait_done("ignore start", 32, 10, 32'd142, 16'd6, 1'b0);

    // Asynchronous reset in the middle of a run
    start_op(32'd2000, 16'd9);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst valid", 64'(valid), 64'd0);
    check("async rst quotient", 64'(quotient), 64'd0);
    check("async rst remainder", 64'(remainder), 64'd0);
    check("async rst dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst idle", 64'(busy), 64'd0);
    start_op(32'd1728, 16'd48);
    wait_done("post rst 1728/48", 32, -1, 32'd36, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_divider_32by16
